// File: rtl/sram_resp_pkg.sv
// Shared definitions for the SRAM-port responder.
// Contents: register-window offsets, the read-source select, and the byte-merge helper.
package sram_resp_pkg;

  localparam logic [15:0] CONF_OFF_LED   = 16'h0000;
  localparam logic [15:0] CONF_OFF_TIMER = 16'h0004;

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_RAM,
    SEL_CONF
  } rd_sel_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_resp_bank.sv
// Word-addressed 32-bit RAM with per-byte write enables and a registered, read-first output.
// Contents are never reset, so the array can map onto FPGA block RAM.
module sram_resp_bank #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata_reg <= mem[idx];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/data_sram_responder.sv
// Responder for the CPU SRAM-style port: byte-enabled RAM with one-cycle read latency.
// Define CONFREG_EN to add the LED/timer register window at addr[31:16] == CONF_BASE.
module data_sram_responder
  import sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] CONF_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led
);

  logic              conf_hit;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       ram_rdata;
  logic [31:0]       conf_rdata;
  rd_sel_t           sel_reg;
  logic              unused_bits;

  assign ram_idx     = sram_addr[ADDR_W+1:2];
  assign unused_bits = ^{sram_addr[31:ADDR_W+2], sram_addr[1:0], CONF_BASE};

  // Gating with resetn drops an access that coincides with reset.
  assign ram_en = sram_en && resetn && !conf_hit;

  sram_resp_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .en    (ram_en),
    .wen   (sram_wen),
    .idx   (ram_idx),
    .wdata (sram_wdata),
    .rdata (ram_rdata)
  );

`ifdef CONFREG_EN
  logic [15:0] led_reg;
  logic [15:0] led_next;
  logic [31:0] timer_reg;
  logic [31:0] timer_next;
  logic [31:0] conf_rdata_reg;
  logic [31:0] conf_rdata_next;
  logic        led_hit;
  logic        timer_hit;

  assign conf_hit  = (sram_addr[31:16] == CONF_BASE);
  assign led_hit   = conf_hit && (sram_addr[15:2] == CONF_OFF_LED[15:2]);
  assign timer_hit = conf_hit && (sram_addr[15:2] == CONF_OFF_TIMER[15:2]);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_led_byte
      assign led_next[8*gi +: 8] = sram_wen[gi] ? sram_wdata[8*gi +: 8] : led_reg[8*gi +: 8];
    end
  endgenerate

  // A write to the timer replaces this cycle's increment.
  assign timer_next = (sram_en && timer_hit && (sram_wen != 4'h0))
                    ? byte_merge(timer_reg, sram_wdata, sram_wen)
                    : timer_reg + 32'd1;

  always_comb begin
    conf_rdata_next = 32'h0;
    if (led_hit)        conf_rdata_next = {16'h0, led_reg};
    else if (timer_hit) conf_rdata_next = timer_reg;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      led_reg        <= 16'h0;
      timer_reg      <= 32'h0;
      conf_rdata_reg <= 32'h0;
    end else begin
      timer_reg <= timer_next;
      if (sram_en && led_hit) led_reg <= led_next;
      if (sram_en && conf_hit) conf_rdata_reg <= conf_rdata_next;
    end
  end

  assign led        = led_reg;
  assign conf_rdata = conf_rdata_reg;
`else
  assign conf_hit   = 1'b0;
  assign led        = 16'h0;
  assign conf_rdata = 32'h0;
`endif

  // The select is registered so it lines up with the bank's registered read data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_reg <= SEL_ZERO;
    end else if (sram_en) begin
      sel_reg <= conf_hit ? SEL_CONF : SEL_RAM;
    end
  end

  always_comb begin
    sram_rdata = 32'h0;
    case (sel_reg)
      SEL_RAM:  sram_rdata = ram_rdata;
      SEL_CONF: sram_rdata = conf_rdata;
      default:  sram_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed scenarios plus randomized traffic against a
// transaction-level memory/register model. Register-window checks need CONFREG_EN.
module tb_data_sram_responder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_wen = 4'h0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] sram_rdata;
  logic [15:0] led;

  always #5 clk = ~clk;

  data_sram_responder #(
    .ADDR_W    (ADDR_W),
    .CONF_BASE (16'hBFAF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .led        (led)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int txn          = 0;

  // Reference model state
  logic [31:0] model_mem   [DEPTH];
  bit          model_known [DEPTH];
  logic [31:0] exp_rdata   = 32'h0;
  bit          exp_known   = 1'b0;
  logic [15:0] exp_led     = 16'h0;
  logic [31:0] timer_base  = 32'h0;
  longint      timer_edge  = 0;
  longint      edge_no     = 0;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] wr_w,
                                              input logic [3:0] strobes);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strobes[b]) r[8*b +: 8] = wr_w[8*b +: 8];
    return r;
  endfunction

  function automatic bit in_window(input logic [31:0] addr);
`ifdef CONFREG_EN
    return addr[31:16] == 16'hBFAF;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    assert (got === want) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // One clock cycle: drive, update model at the edge, then compare shortly after.
  task automatic cycle(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic rst_n, input string tag);
    int          idx;
    logic [31:0] tval;
    logic [31:0] tmp;
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wdata;
    resetn     = rst_n;
    @(posedge clk);
    edge_no++;
    tval = timer_base + 32'(edge_no - timer_edge - 1);
    if (!rst_n) begin
      exp_rdata  = 32'h0;
      exp_known  = 1'b1;
      exp_led    = 16'h0;
      timer_base = 32'h0;
      timer_edge = edge_no;
    end else if (en) begin
      if (in_window(addr)) begin
        exp_known = 1'b1;
        if (addr[15:2] == 14'd0) begin
          exp_rdata = {16'h0, exp_led};
          tmp = merge_bytes({16'h0, exp_led}, wdata, {2'b00, wen[1:0]});
          exp_led = tmp[15:0];
        end else if (addr[15:2] == 14'd1) begin
          exp_rdata = tval;
          if (wen != 4'h0) begin
            timer_base = merge_bytes(tval, wdata, wen);
            timer_edge = edge_no;
          end
        end else begin
          exp_rdata = 32'h0;
        end
      end else begin
        idx = int'(addr[ADDR_W+1:2]);
        exp_rdata = model_mem[idx];
        exp_known = model_known[idx];
        if (wen == 4'hF) begin
          model_mem[idx]   = wdata;
          model_known[idx] = 1'b1;
        end else if (wen != 4'h0 && model_known[idx]) begin
          model_mem[idx] = merge_bytes(model_mem[idx], wdata, wen);
        end
      end
    end
    #1;
    txn++;
    $display("[TB] txn %0d %s rst_n=%0b en=%0b wen=%h addr=%h wdata=%h rdata=%h led=%h",
             txn, tag, rst_n, en, wen, addr, wdata, sram_rdata, led);
    if (exp_known) check({tag, "_rdata"}, sram_rdata, exp_rdata);
    check({tag, "_led"}, {16'h0, led}, {16'h0, exp_led});
  endtask

  initial begin
    logic        r_en;
    logic        r_rst;
    logic [3:0]  r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_data;

    for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, "reset0");
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, "reset1");
    check("reset_rdata", sram_rdata, 32'h0);

    // Full write then read
    cycle(1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678, 1'b1, "t1_wr");
    cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1, "t1_rd");
    check("t1_value", sram_rdata, 32'h1234_5678);

    // Byte-lane write is read-first
    cycle(1'b1, 4'b0010, 32'h0000_0100, 32'hAABB_CCDD, 1'b1, "t2_wr");
    check("t2_write_cycle_old", sram_rdata, 32'h1234_5678);
    cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1, "t2_rd");
    check("t2_merged", sram_rdata, 32'h1234_CC78);

    // Aliasing above the RAM size
    cycle(1'b1, 4'hF, 32'h0000_4000, 32'hDEAD_BEEF, 1'b1, "t3_wr");
    cycle(1'b1, 4'h0, 32'h0000_0000, 32'h0, 1'b1, "t3_rd");
    check("t3_alias", sram_rdata, 32'hDEAD_BEEF);

    // Hold while idle, then clear on reset
    cycle(1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_F00D, 1'b1, "t4_wr");
    cycle(1'b1, 4'h0, 32'h0000_0200, 32'h0, 1'b1, "t4_rd");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'hF, 32'h0000_0100, 32'h5555_5555, 1'b1, "t4_idle");
      check("t4_hold", sram_rdata, 32'hCAFE_F00D);
    end
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, "t4_rst");
    check("t4_reset_clears", sram_rdata, 32'h0);

    // Access during reset is dropped
    cycle(1'b1, 4'hF, 32'h0000_0300, 32'h1111_1111, 1'b1, "rm_wr");
    cycle(1'b1, 4'hF, 32'h0000_0300, 32'h9999_9999, 1'b0, "rm_rst_wr");
    cycle(1'b1, 4'h0, 32'h0000_0300, 32'h0, 1'b1, "rm_rd");
    check("reset_drops_write", sram_rdata, 32'h1111_1111);

`ifdef CONFREG_EN
    cycle(1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_00A5, 1'b1, "t5_wr");
    check("t5_led", {16'h0, led}, 32'h0000_00A5);
    cycle(1'b1, 4'h0, 32'hBFAF_0000, 32'h0, 1'b1, "t5_rd");
    check("t5_led_read", sram_rdata, 32'h0000_00A5);
    cycle(1'b1, 4'h0, 32'h0000_0000, 32'h0, 1'b1, "t5_ram");
    check("t5_ram_untouched", sram_rdata, 32'hDEAD_BEEF);

    cycle(1'b1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFE, 1'b1, "t6_wr");
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, "t6_idle");
    cycle(1'b1, 4'h0, 32'hBFAF_0004, 32'h0, 1'b1, "t6_rd");
    check("t6_timer_wrap", sram_rdata, 32'h0000_0001);
`endif

    // Randomized traffic over a small set of word indices with random aliasing high bits
    for (int n = 0; n < 300; n++) begin
      r_en  = ($urandom_range(0, 3) != 0);
      r_rst = ($urandom_range(0, 49) != 0);
      r_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      r_addr = {18'($urandom()), 12'($urandom_range(0, 15)), 2'($urandom())};
`ifdef CONFREG_EN
      if ($urandom_range(0, 5) == 0)
        r_addr = {16'hBFAF, 14'($urandom_range(0, 2)), 2'b00};
`endif
      r_data = $urandom();
      cycle(r_en, r_wen, r_addr, r_data, r_rst, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
